// File: rtl/bpu_res_arbiter.sv
// bpu_res_arbiter: schedules branch/jump unit resolutions into the single bpu update port.
// Optional statistics counters are built when BPU_RES_STATS_EN is defined.
package mmm_pkg;
    localparam int XLEN = 32;
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            mispredict;
    } resolution_t;
endpackage

module bpu_res_arbiter
    import mmm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  resolution_t req0_res_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  resolution_t req1_res_i,
    output resolution_t bpu_res_o
`ifdef BPU_RES_STATS_EN
    ,
    output logic [31:0] stat_updates_o,
    output logic [31:0] stat_mispred_o,
    output logic [31:0] stat_stall_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]  req_valid, push, ne, full, pop_src;
    resolution_t req_res [2];
    resolution_t head [2];
    logic        both, mp_pri, sel, pop, rr_ptr;

    assign req_valid    = {req1_valid_i, req0_valid_i};
    assign req_res[0]   = req0_res_i;
    assign req_res[1]   = req1_res_i;
    assign req0_ready_o = !full[0];
    assign req1_ready_o = !full[1];
    assign push         = req_valid & ~full & {2{!flush_i}};

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        resolution_t   mem [DEPTH];
        logic [AW-1:0] wp, rp;
        logic [CW-1:0] cnt;
        assign full[s] = cnt == CW'(DEPTH);
        assign ne[s]   = cnt != '0;
        assign head[s] = mem[rp];
        // pointers and occupancy; flush empties the queue ahead of any push or pop
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else if (flush_i) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push[s]) wp <= wp + 1'b1;
                if (pop_src[s]) rp <= rp + 1'b1;
                cnt <= cnt + CW'(push[s]) - CW'(pop_src[s]);
            end
        end
        // storage needs no reset: occupancy alone decides what is live
        always_ff @(posedge clk_i) begin
            if (push[s]) mem[wp] <= req_res[s];
        end
    end

    // winner: lone head, else the lone mispredict, else the round-robin pick
    always_comb begin
        both    = &ne;
        mp_pri  = both && (head[0].mispredict ^ head[1].mispredict);
        sel     = !both ? ne[1] : mp_pri ? head[1].mispredict : rr_ptr;
        pop     = |ne && !flush_i;
        pop_src = !pop ? 2'b00 : sel ? 2'b10 : 2'b01;
    end

    // pointer advances only when round-robin actually decided the pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_ptr <= 1'b0;
        else if (pop && both && !mp_pri) rr_ptr <= !sel;
    end

    // registered update: valid for one cycle per pop, payload held otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bpu_res_o <= '0;
        end else if (pop) begin
            bpu_res_o       <= head[sel];
            bpu_res_o.valid <= 1'b1;
        end else begin
            bpu_res_o.valid <= 1'b0;
        end
    end

`ifdef BPU_RES_STATS_EN
    logic stall;
    assign stall = |(req_valid & full);
    // saturating statistics, untouched by flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
            stat_stall_o   <= '0;
        end else begin
            if (pop && stat_updates_o != '1) stat_updates_o <= stat_updates_o + 1'b1;
            if (pop && head[sel].mispredict && stat_mispred_o != '1) stat_mispred_o <= stat_mispred_o + 1'b1;
            if (stall && stat_stall_o != '1) stat_stall_o <= stat_stall_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bpu_res_arbiter.sv
// tb_bpu_res_arbiter: directed scoreboard bench for bpu_res_arbiter.
module tb_bpu_res_arbiter;
    import mmm_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    resolution_t req0_res_i, req1_res_i, bpu_res_o;
`ifdef BPU_RES_STATS_EN
    logic [31:0] stat_updates_o, stat_mispred_o, stat_stall_o;
`endif

    int          checks = 0;
    int          failures = 0;
    resolution_t exp_q[$];
    resolution_t mon_e, r;
    int          acc, cyc;
    bit          took, exp_rdy;

    bpu_res_arbiter #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_res_i(req0_res_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_res_i(req1_res_i),
        .bpu_res_o(bpu_res_o)
`ifdef BPU_RES_STATS_EN
        , .stat_updates_o(stat_updates_o), .stat_mispred_o(stat_mispred_o), .stat_stall_o(stat_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic resolution_t mk(int pc, int tgt, bit tk, bit mp);
        resolution_t x;
        x            = '0;
        x.pc         = XLEN'(pc);
        x.target     = XLEN'(tgt);
        x.taken      = tk;
        x.mispredict = mp;
        return x;
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(string tag, int n);
        repeat (n) tick();
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && bpu_res_o.valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", bpu_res_o.valid, 1'b0);
            end else begin
                mon_e       = exp_q.pop_front();
                mon_e.valid = 1'b1;
                check("sb_entry", bpu_res_o, mon_e);
            end
        end
    end

    initial begin
        rst_i = 1; flush_i = 0; req0_valid_i = 0; req1_valid_i = 0;
        req0_res_i = '0; req1_res_i = '0;
        #2;
        check("rst_out", bpu_res_o, 128'(0));
        check("rst_rdy", {req0_ready_o, req1_ready_o}, 2'b11);
        tick(); tick();
        rst_i = 0;

        // single push, two-edge latency, one-cycle pulse
        req0_valid_i = 1; req0_res_i = mk(10, 4, 1, 0);
        exp_q.push_back(mk(10, 4, 1, 0));
        tick();
        req0_valid_i = 0;
        check("t1_lat", bpu_res_o.valid, 1'b0);
        tick();
        r = mk(10, 4, 1, 0); r.valid = 1;
        check("t1_out", bpu_res_o, r);
        tick();
        check("t1_low", bpu_res_o.valid, 1'b0);
        drain("t1_drain", 3);

        // both sources, four entries each: strict alternation starting at src0
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(100 + i, 20, 0, 0));
            exp_q.push_back(mk(200 + i, 30, 1, 0));
        end
        for (int i = 0; i < 4; i++) begin
            req0_valid_i = 1; req0_res_i = mk(100 + i, 20, 0, 0);
            req1_valid_i = 1; req1_res_i = mk(200 + i, 30, 1, 0);
            tick();
        end
        req0_valid_i = 0; req1_valid_i = 0;
        drain("t2_drain", 10);

        // pointer now favours src1; one round-robin pop returns it to src0
        exp_q.push_back(mk(300, 1, 0, 0));
        exp_q.push_back(mk(301, 1, 0, 0));
        req0_valid_i = 1; req0_res_i = mk(301, 1, 0, 0);
        req1_valid_i = 1; req1_res_i = mk(300, 1, 0, 0);
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        drain("t_rr_drain", 4);

        // mispredict on src1 jumps the queue, pointer stays on src0
        exp_q.push_back(mk(410, 7, 1, 1));
        exp_q.push_back(mk(400, 6, 0, 0));
        req0_valid_i = 1; req0_res_i = mk(400, 6, 0, 0);
        req1_valid_i = 1; req1_res_i = mk(410, 7, 1, 1);
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        drain("t3_drain", 4);
        exp_q.push_back(mk(500, 8, 0, 0));
        exp_q.push_back(mk(510, 9, 0, 0));
        req0_valid_i = 1; req0_res_i = mk(500, 8, 0, 0);
        req1_valid_i = 1; req1_res_i = mk(510, 9, 0, 0);
        tick();
        req0_valid_i = 0; req1_valid_i = 0;
        drain("t3b_drain", 4);

        // src0 fills while src1 mispredicts hold the port
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(600 + i, 60, 1, 1));
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(700 + i, 70, 0, 0));
        acc = 0; cyc = 0;
        while (cyc < 12 && acc < 5) begin
            req1_valid_i = cyc < 5; req1_res_i = mk(600 + cyc, 60, 1, 1);
            req0_valid_i = 1;       req0_res_i = mk(700 + acc, 70, 0, 0);
            exp_rdy = !(cyc >= 4 && cyc <= 6);
            check("t4_rdy", req0_ready_o, exp_rdy);
            took = req0_ready_o;
            tick();
            if (took) acc++;
            cyc++;
        end
        req0_valid_i = 0; req1_valid_i = 0;
        check("t4_cycles", cyc, 8);
        drain("t4_drain", 8);
`ifdef BPU_RES_STATS_EN
        check("stat_upd", stat_updates_o, 25);
        check("stat_mp", stat_mispred_o, 6);
        check("stat_stall", stat_stall_o, 3);
`endif

        // flush with backlog and a simultaneous src1 push
        exp_q.push_back(mk(900, 90, 0, 0));
        exp_q.push_back(mk(800, 80, 0, 0));
        exp_q.push_back(mk(901, 90, 0, 0));
        for (int i = 0; i < 4; i++) begin
            req0_valid_i = 1; req0_res_i = mk(800 + i, 80, 0, 0);
            req1_valid_i = 1; req1_res_i = mk(900 + i, 90, 0, 0);
            tick();
        end
        flush_i = 1; req0_valid_i = 0;
        req1_valid_i = 1; req1_res_i = mk(999, 99, 1, 1);
        tick();
        flush_i = 0; req1_valid_i = 0;
        check("t5_noval", bpu_res_o.valid, 1'b0);
        check("t5_rdy", {req0_ready_o, req1_ready_o}, 2'b11);
        drain("t5_drain", 6);
`ifdef BPU_RES_STATS_EN
        check("stat_upd_fl", stat_updates_o, 28);
`endif

        // asynchronous reset mid-stream discards everything
        exp_q.push_back(mk(1000, 11, 0, 0));
        exp_q.push_back(mk(1100, 12, 0, 0));
        for (int i = 0; i < 3; i++) begin
            req0_valid_i = 1; req0_res_i = mk(1000 + i, 11, 0, 0);
            req1_valid_i = 1; req1_res_i = mk(1100 + i, 12, 0, 0);
            tick();
        end
        req0_valid_i = 0; req1_valid_i = 0;
        #6;
        rst_i = 1;
        #1;
        check("t6_out", bpu_res_o, 128'(0));
        check("t6_rdy", {req0_ready_o, req1_ready_o}, 2'b11);
        check("t6_sb", exp_q.size(), 0);
`ifdef BPU_RES_STATS_EN
        check("t6_stats", {stat_updates_o, stat_mispred_o, stat_stall_o}, 96'(0));
`endif
        tick(); tick();
        rst_i = 0;
        drain("t6_empty", 6);
        exp_q.push_back(mk(1200, 13, 1, 0));
        req0_valid_i = 1; req0_res_i = mk(1200, 13, 1, 0);
        tick();
        req0_valid_i = 0;
        drain("t6_resume", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
